back_tile_draw: RTL and testbench

BACK_TILE_DRAW -- requirements
Module: back_tile_draw

---
 rtl/back_tile_draw_pkg.sv | 17 +
 rtl/back_tile_shifter.sv | 50 +++++
 rtl/back_tile_draw.sv | 141 ++++++++++++++
 tb/tb_back_tile_draw.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/back_tile_draw_pkg.sv
// Shared PPU definitions for the background tile drawer: widths, screen and
// nametable geometry, and the drawer FSM state encodings.
package back_tile_draw_pkg;

  localparam int TILE_ADDR_W = 11;  // {tile_id[7:0], fine_row[2:0]}
  localparam int TILE_DATA_W = 32;  // 8 pixels x 4 bits
  localparam int PIX_W       = 4;
  localparam int SCREEN_W    = 256;
  localparam int NT_COLS     = 32;
  localparam int NT_ROWS     = 32;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREFETCH = 2'd1;
  localparam logic [1:0] ST_READY    = 2'd2;
  localparam logic [1:0] ST_DRAW     = 2'd3;

endpackage

// File: rtl/back_tile_shifter.sv
// Pixel shift register, next-tile latch and 3-bit pixel-in-tile counter.
// Each step emits the top nibble; the 8th step of a tile reloads from the latch.
module back_tile_shifter
  import back_tile_draw_pkg::*;
#(
  parameter int DATA_W = TILE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load_shift,
  input  logic              load_latch,
  input  logic              step,
  input  logic [DATA_W-1:0] rom_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              tile_last
);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] latch_q;
  logic [2:0]        pix_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      latch_q <= '0;
      pix_cnt <= '0;
    end else if (clr) begin
      shift_q <= '0;
      latch_q <= '0;
      pix_cnt <= '0;
    end else begin
      if (load_shift) begin
        shift_q <= rom_data;
      end else if (step) begin
        shift_q <= tile_last ? latch_q : {shift_q[DATA_W-PIX_W-1:0], {PIX_W{1'b0}}};
      end
      if (load_latch) begin
        latch_q <= rom_data;
      end
      if (step) begin
        pix_cnt <= pix_cnt + 3'd1;
      end
    end
  end

  assign pix_out   = shift_q[DATA_W-1 -: PIX_W];
  assign tile_last = (pix_cnt == 3'd7);

endmodule

// File: rtl/back_tile_draw.sv
// Background tile drawer: prefetches two tiles for the current scanline, then
// streams 256 pixels while fetching each following tile through nametable and tile ROM.
module back_tile_draw
  import back_tile_draw_pkg::*;
#(
  parameter int TILEROM_ADDRBIT = TILE_ADDR_W,
  parameter int TILEDATA_BIT    = TILE_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       line_start,
  input  logic [7:0]                 line_y,
  input  logic [7:0]                 scroll_y,
  input  logic                       pix_start,
  output logic [9:0]                 nt_addr,
  input  logic [7:0]                 nt_data,
  output logic [TILEROM_ADDRBIT-1:0] backTileIndex,
  input  logic [TILEDATA_BIT-1:0]    backTileDataI,
  output logic                       ready,
  output logic                       pix_valid,
  output logic [3:0]                 pix_color,
  output logic [1:0]                 dbg_state
);

  // Handshake: ready is high only in READY; a pix_start seen while ready is high
  // (and line_start is low) is accepted and pixel 0 appears on the next cycle.
  // pix_start in any other cycle is dropped. line_start always wins.

  logic [1:0]                 state;
  logic [7:0]                 vy;
  logic [1:0]                 pf_cnt;
  logic [1:0]                 fphase;
  logic [4:0]                 fetch_col;
  logic [4:0]                 tile_cnt;
  logic [TILEROM_ADDRBIT-1:0] idx_q;
  logic [TILEROM_ADDRBIT-1:0] idx_next;
  logic [7:0]                 vy_next;
  logic [4:0]                 col_next;
  logic                       cap_shift;
  logic                       cap_latch;
  logic                       emit;
  logic                       tile_last;
  logic [3:0]                 pix_out;

  assign vy_next   = line_y + scroll_y;
  assign col_next  = fetch_col + 5'd1;
  assign idx_next  = TILEROM_ADDRBIT'({nt_data, vy[2:0]});
  assign dbg_state = state;

  // ROM is combinational, so the index is presented in the capture cycle itself.
  always_comb begin
    cap_shift     = !line_start && (state == ST_PREFETCH) && (pf_cnt == 2'd1);
    cap_latch     = !line_start && (((state == ST_PREFETCH) && (pf_cnt == 2'd3)) ||
                                    ((state == ST_DRAW) && (fphase == 2'd2)));
    emit          = !line_start && (((state == ST_READY) && pix_start) || (state == ST_DRAW));
    backTileIndex = (cap_shift || cap_latch) ? idx_next : idx_q;
    ready         = (state == ST_READY);
  end

  back_tile_shifter #(
    .DATA_W(TILEDATA_BIT)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clr       (line_start),
    .load_shift(cap_shift),
    .load_latch(cap_latch),
    .step      (emit),
    .rom_data  (backTileDataI),
    .pix_out   (pix_out),
    .tile_last (tile_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      vy        <= '0;
      pf_cnt    <= '0;
      fphase    <= '0;
      fetch_col <= '0;
      tile_cnt  <= '0;
      idx_q     <= '0;
      nt_addr   <= '0;
      pix_valid <= 1'b0;
      pix_color <= '0;
    end else if (line_start) begin
      state     <= ST_PREFETCH;
      vy        <= vy_next;
      pf_cnt    <= '0;
      fphase    <= '0;
      fetch_col <= '0;
      tile_cnt  <= '0;
      nt_addr   <= {vy_next[7:3], 5'd0};
      pix_valid <= 1'b0;
      pix_color <= '0;
    end else begin
      if (cap_shift || cap_latch) begin
        idx_q <= idx_next;
      end
      pix_valid <= emit;
      pix_color <= emit ? pix_out : 4'd0;
      case (state)
        ST_PREFETCH: begin
          pf_cnt <= pf_cnt + 2'd1;
          if (pf_cnt == 2'd1) begin
            fetch_col <= 5'd1;
            nt_addr   <= {vy[7:3], 5'd1};
          end
          if (pf_cnt == 2'd3) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (pix_start) begin
            state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (fphase == 2'd1) begin
            fphase <= 2'd2;
          end else if (fphase == 2'd2) begin
            fphase <= 2'd0;
          end
          // Tile boundary: shifter reloads from the latch; refill the latch with the next column.
          if (tile_last) begin
            tile_cnt <= tile_cnt + 5'd1;
            if (tile_cnt == 5'd31) begin
              state <= ST_IDLE;
            end else begin
              fetch_col <= col_next;
              nt_addr   <= {vy[7:3], col_next};
              fphase    <= 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_back_tile_draw.sv
// Bench for back_tile_draw: external nametable RAM / tile ROM models, a
// table of scroll vectors, full-line pixel runs against a reference model, and abort/reset sequences.
module tb_back_tile_draw;
  import back_tile_draw_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [7:0]  line_y;
  logic [7:0]  scroll_y;
  logic        pix_start;
  logic [9:0]  nt_addr;
  logic [7:0]  nt_data;
  logic [10:0] backTileIndex;
  logic [31:0] backTileDataI;
  logic        ready;
  logic        pix_valid;
  logic [3:0]  pix_color;
  logic [1:0]  dbg_state;

  logic [7:0]  nt_mem  [0:1023];
  logic [31:0] rom_mem [0:2047];
  logic [3:0]  exp_q[$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y;
    logic [7:0] s;
    logic [4:0] row;
    logic [2:0] fine;
  } vec_t;

  // clock / reset / memory models
  always #5 clk = ~clk;

  always @(posedge clk) nt_data <= nt_mem[nt_addr];
  assign backTileDataI = rom_mem[backTileIndex];

  back_tile_draw dut (
    .clk          (clk),
    .rst          (rst),
    .line_start   (line_start),
    .line_y       (line_y),
    .scroll_y     (scroll_y),
    .pix_start    (pix_start),
    .nt_addr      (nt_addr),
    .nt_data      (nt_data),
    .backTileIndex(backTileIndex),
    .backTileDataI(backTileDataI),
    .ready        (ready),
    .pix_valid    (pix_valid),
    .pix_color    (pix_color),
    .dbg_state    (dbg_state)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference model: pixel p of the line comes from nametable column p/8
  task automatic build_exp(input logic [7:0] y, input logic [7:0] s);
    logic [7:0]  v;
    logic [7:0]  tile;
    logic [31:0] row;
    v = 8'((int'(y) + int'(s)) % 256);
    exp_q.delete();
    for (int p = 0; p < SCREEN_W; p++) begin
      tile = nt_mem[{v[7:3], 5'(p / 8)}];
      row  = rom_mem[{tile, v[2:0]}];
      exp_q.push_back(row[31 - 4 * (p % 8) -: 4]);
    end
  endtask

  // driver tasks
  task automatic pulse_line(input logic [7:0] y, input logic [7:0] s);
    line_y     = y;
    scroll_y   = s;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    line_y     = 8'($urandom);
    scroll_y   = 8'($urandom);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, n, 4);
  endtask

  task automatic pulse_pix;
    pix_start = 1'b1;
    @(negedge clk);
    pix_start = 1'b0;
  endtask

  task automatic draw_pixels(input string name, input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      check({name, "_valid"}, pix_valid, 1'b1);
      check({name, "_color"}, pix_color, e);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check({name, "_valid"}, pix_valid, 1'b0);
      check({name, "_color"}, pix_color, 4'd0);
      @(negedge clk);
    end
  endtask

  task automatic full_line(input string name, input logic [7:0] y, input logic [7:0] s);
    build_exp(y, s);
    pulse_line(y, s);
    wait_ready({name, "_ready"});
    pulse_pix();
    draw_pixels(name, 256);
    check_idle({name, "_tail"}, 4);
  endtask

  task automatic fill_random;
    for (int i = 0; i < 1024; i++) nt_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom_mem[i] = $urandom;
  endtask

  vec_t vecs[8];

  initial begin
    rst = 1'b1; line_start = 1'b0; pix_start = 1'b0; line_y = '0; scroll_y = '0;
    fill_random();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_valid", pix_valid, 1'b0);
    check("rst_color", pix_color, 4'd0);
    check("rst_ready", ready, 1'b0);
    check("rst_nt_addr", nt_addr, 10'd0);
    check("rst_tile_idx", backTileIndex, 11'd0);
    check("rst_state", dbg_state, ST_IDLE);
    pulse_pix();
    check_idle("idle_pix_start", 3);
    check("idle_ready", ready, 1'b0);

    // scroll vectors: row and fine-row fields of the fetch addresses
    vecs[0] = '{8'd0,   8'd0,   5'd0,  3'd0};
    vecs[1] = '{8'd250, 8'd10,  5'd0,  3'd4};
    vecs[2] = '{8'd255, 8'd1,   5'd0,  3'd0};
    vecs[3] = '{8'd100, 8'd37,  5'd17, 3'd1};
    vecs[4] = '{8'd200, 8'd200, 5'd18, 3'd0};
    vecs[5] = '{8'd7,   8'd0,   5'd0,  3'd7};
    vecs[6] = '{8'd128, 8'd127, 5'd31, 3'd7};
    vecs[7] = '{8'd20,  8'd43,  5'd7,  3'd7};
    foreach (vecs[k]) begin
      pulse_line(vecs[k].y, vecs[k].s);
      check("vec_nt_addr_col0", nt_addr, {vecs[k].row, 5'd0});
      wait_ready("vec_ready");
      check("vec_nt_addr_col1", nt_addr, {vecs[k].row, 5'd1});
      check("vec_tile_fine", backTileIndex[2:0], vecs[k].fine);
      check("vec_tile_id", backTileIndex[10:3], nt_mem[{vecs[k].row, 5'd1}]);
    end

    // constant tile 0x05 with ramp row data
    for (int i = 0; i < 1024; i++) nt_mem[i] = 8'h05;
    for (int r = 0; r < 8; r++) rom_mem[{8'h05, 3'(r)}] = 32'h0123_4567;
    full_line("const5", 8'd0, 8'd0);

    // column c holds tile c; row data names its tile
    for (int i = 0; i < 1024; i++) nt_mem[i] = 8'(i % 32);
    for (int i = 0; i < 2048; i++) rom_mem[i] = {8'(i >> 3), 8'(i & 7), ~8'(i >> 3), 8'(i >> 3)};
    full_line("colid", 8'd17, 8'd3);

    fill_random();
    for (int n = 0; n < 3; n++) full_line("rand", 8'($urandom), 8'($urandom_range(0, 255)));

    // pix_start during PREFETCH is ignored
    build_exp(8'd40, 8'd9);
    pulse_line(8'd40, 8'd9);
    @(negedge clk);
    pulse_pix();
    check("pf_ign_valid_a", pix_valid, 1'b0);
    check("pf_ign_ready_a", ready, 1'b0);
    @(negedge clk);
    check("pf_ign_valid_b", pix_valid, 1'b0);
    check("pf_ign_ready_b", ready, 1'b0);
    @(negedge clk);
    check("pf_ign_valid_c", pix_valid, 1'b0);
    check("pf_ign_ready_c", ready, 1'b1);
    repeat (3) @(negedge clk);
    check("ready_hold", ready, 1'b1);
    check("ready_hold_valid", pix_valid, 1'b0);
    pulse_pix();
    draw_pixels("after_pf", 256);
    check_idle("after_pf_tail", 2);

    // line_start at pixel 100 aborts and restarts
    build_exp(8'd60, 8'd70);
    pulse_line(8'd60, 8'd70);
    wait_ready("abort_ready1");
    pulse_pix();
    draw_pixels("pre_abort", 100);
    build_exp(8'd33, 8'd250);
    pulse_line(8'd33, 8'd250);
    check("abort_valid", pix_valid, 1'b0);
    check("abort_color", pix_color, 4'd0);
    wait_ready("abort_ready2");
    pulse_pix();
    draw_pixels("post_abort", 256);
    check_idle("post_abort_tail", 2);

    // line_start wins over a simultaneous pix_start in READY
    build_exp(8'd5, 8'd5);
    pulse_line(8'd5, 8'd5);
    wait_ready("tie_ready1");
    pix_start = 1'b1;
    pulse_line(8'd5, 8'd5);
    pix_start = 1'b0;
    check("tie_valid", pix_valid, 1'b0);
    wait_ready("tie_ready2");
    pulse_pix();
    draw_pixels("tie", 256);
    check_idle("tie_tail", 2);

    // asynchronous reset at pixel 50
    build_exp(8'd90, 8'd1);
    pulse_line(8'd90, 8'd1);
    wait_ready("rst_mid_ready");
    pulse_pix();
    draw_pixels("pre_rst", 50);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", pix_valid, 1'b0);
    check("rst_mid_color", pix_color, 4'd0);
    check("rst_mid_ready", ready, 1'b0);
    check("rst_mid_nt_addr", nt_addr, 10'd0);
    check("rst_mid_tile_idx", backTileIndex, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_pix();
    check_idle("rst_pix_ign", 4);
    check("rst_post_ready", ready, 1'b0);
    full_line("post_rst", 8'd90, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
